// File: rtl/huffman_encoder.sv
// huffman_encoder: serialising Huffman encoder, transmit-side partner of the
// bit-serial huffman_decoder. Takes 3-bit symbols over valid/ready and shifts
// the prefix code out MSB first, one bit per clk, with no gap between codes.
//
// Handshake: a symbol is taken on the rising clk edge where
// sym_valid && sym_ready. sym_ready depends only on internal state. sym_in is
// sampled only on that edge. bit_out is meaningful only while bit_valid=1.
//
// busy mirrors the FSM state (1 = SHIFT) and serves as its debug view.
//
// Optional feature macro: HUFF_ENC_STATS_EN enables the sym_count/bit_count
// statistics counters. Without it both outputs are tied to zero.
module huffman_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] sym_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t     state, state_next;
    logic [3:0] code_sr, code_next;
    logic [2:0] rem, rem_next;
    logic       err_next;

    logic [3:0] lut_code;
    logic [2:0] lut_len;
    logic       lut_ok;
    logic       accept;

    // Codebook lookup: left-aligned code, its length, and whether the symbol has a code.
    always_comb begin
        lut_code = 4'b0000;
        lut_len  = 3'd0;
        lut_ok   = 1'b1;
        case (sym_in)
            3'b001:  begin lut_code = 4'b0000; lut_len = 3'd1; end
            3'b011:  begin lut_code = 4'b1000; lut_len = 3'd3; end
            3'b010:  begin lut_code = 4'b1010; lut_len = 3'd3; end
            3'b100:  begin lut_code = 4'b1110; lut_len = 3'd3; end
            3'b110:  begin lut_code = 4'b1100; lut_len = 3'd4; end
            3'b101:  begin lut_code = 4'b1101; lut_len = 3'd4; end
            default: lut_ok = 1'b0;
        endcase
    end

    // Ready in IDLE, or on the last bit of a code so the next code follows without a gap.
    assign sym_ready = (state == IDLE) || (state == SHIFT && rem == 3'd1);
    assign accept    = sym_valid && sym_ready;

    assign busy      = (state == SHIFT);
    assign bit_valid = (state == SHIFT);
    assign bit_out   = (state == SHIFT) ? code_sr[3] : 1'b0;

    // Next-state logic: load on accept, shift while in SHIFT, flag rejected symbols.
    always_comb begin
        state_next = state;
        code_next  = code_sr;
        rem_next   = rem;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (lut_ok) begin
                        code_next  = lut_code;
                        rem_next   = lut_len;
                        state_next = SHIFT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                code_next = {code_sr[2:0], 1'b0};
                rem_next  = rem - 3'd1;
                if (rem == 3'd1) begin
                    if (accept && lut_ok) begin
                        code_next  = lut_code;
                        rem_next   = lut_len;
                        state_next = SHIFT;
                    end else begin
                        err_next   = accept;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, shift register and error pulse; reset drops any code in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            code_sr <= 4'b0000;
            rem     <= 3'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            code_sr <= code_next;
            rem     <= rem_next;
            err     <= err_next;
        end
    end

`ifdef HUFF_ENC_STATS_EN
    logic [CNT_W-1:0] sym_cnt_q, bit_cnt_q;

    // Statistics: accepted valid symbols and emitted code bits, wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            if (accept && lut_ok) sym_cnt_q <= sym_cnt_q + 1'b1;
            if (bit_valid)        bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    assign sym_count = sym_cnt_q;
    assign bit_count = bit_cnt_q;
`else
    assign sym_count = '0;
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// tb_huffman_encoder: drives directed and random symbol streams into
// huffman_encoder and compares every cycle against a queue-based model of the
// expected serial bit stream; a behavioural loopback decoder turns bit_out
// back into symbols and compares them with the accepted-symbol queue.
module tb_huffman_encoder;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [2:0]       sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] sym_count;
    logic [CNT_W-1:0] bit_count;

    huffman_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .err       (err),
        .sym_count (sym_count),
        .bit_count (bit_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codebook indexed by symbol; length 0 means the symbol has no code.
    int code_val [8] = '{0, 0, 5, 4, 7, 13, 12, 0};
    int code_len [8] = '{0, 1, 3, 3, 3, 4, 4, 0};

    // scoreboard state
    logic             exp_q[$];      // code bits still to appear on bit_out
    logic [2:0]       sym_q[$];      // symbols the loopback decoder must reproduce
    logic             err_pend;
    logic [CNT_W-1:0] m_sym_cnt;
    logic [CNT_W-1:0] m_bit_cnt;
    int               dec_val;
    int               dec_len;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_counters();
        logic [CNT_W-1:0] es, eb;
`ifdef HUFF_ENC_STATS_EN
        es = m_sym_cnt;
        eb = m_bit_cnt;
`else
        es = '0;
        eb = '0;
`endif
        check("sym_count", 32'(sym_count), 32'(es));
        check("bit_count", 32'(bit_count), 32'(eb));
    endtask

    // Behavioural decoder fed by the DUT serial stream.
    task automatic loopback(input logic b);
        int found;
        dec_val = (dec_val << 1) | int'(b);
        dec_len++;
        found = -1;
        for (int s = 0; s < 8; s++)
            if (code_len[s] == dec_len && code_val[s] == dec_val) found = s;
        if (found >= 0) begin
            if (sym_q.size() == 0) check("loop_extra", 32'(found), 32'hFFFF);
            else check("loop_sym", 32'(found), 32'(sym_q.pop_front()));
            dec_val = 0;
            dec_len = 0;
        end else if (dec_len >= 4) begin
            check("loop_code", 32'(dec_val), 32'hFFFF);
            dec_val = 0;
            dec_len = 0;
        end
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input logic v, input logic [2:0] s);
        logic exp_bv, exp_bo, exp_rdy;
        exp_bv  = (exp_q.size() != 0);
        exp_bo  = exp_bv ? exp_q[0] : 1'b0;
        exp_rdy = (exp_q.size() <= 1);
        check("bit_valid", 32'(bit_valid), 32'(exp_bv));
        check("bit_out",   32'(bit_out),   32'(exp_bo));
        check("busy",      32'(busy),      32'(exp_bv));
        check("sym_ready", 32'(sym_ready), 32'(exp_rdy));
        check("err",       32'(err),       32'(err_pend));
        check_counters();
        if (bit_valid === 1'b1) loopback(bit_out);

        sym_valid = v;
        sym_in    = s;
        @(posedge clk);
        #1;

        if (exp_bv) begin
            void'(exp_q.pop_front());
            m_bit_cnt++;
        end
        err_pend = 1'b0;
        if (v && exp_rdy) begin
            if (code_len[s] == 0) begin
                err_pend = 1'b1;
            end else begin
                for (int i = code_len[s] - 1; i >= 0; i--)
                    exp_q.push_back(((code_val[s] >> i) & 1) != 0);
                m_sym_cnt++;
                sym_q.push_back(s);
            end
        end
    endtask

    task automatic apply_reset();
        sym_valid = 1'b0;
        sym_in    = 3'b000;
        reset     = 1'b1;
        #2;
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_bit_out",   32'(bit_out),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_sym_count", 32'(sym_count), 32'd0);
        check("rst_bit_count", 32'(bit_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        sym_q.delete();
        err_pend  = 1'b0;
        m_sym_cnt = '0;
        m_bit_cnt = '0;
        dec_val   = 0;
        dec_len   = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'($urandom_range(0, 7)));
    endtask

    initial begin
        apply_reset();

        // single 1-bit code
        step(1'b1, 3'b001);
        idle(3);

        // back-to-back 101 then 110 with valid held: 1101 1100 gapless
        step(1'b1, 3'b101);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b110);
        idle(6);

        // invalid symbols in IDLE
        step(1'b1, 3'b111);
        idle(2);
        step(1'b1, 3'b000);
        idle(2);

        // invalid symbol on the last bit of a code ends the stream with err
        step(1'b1, 3'b011);
        step(1'b0, 3'b000);
        step(1'b1, 3'b111);
        step(1'b1, 3'b111);
        idle(3);

        // reset after two bits of 100, then a clean 011
        step(1'b1, 3'b100);
        idle(2);
        apply_reset();
        step(1'b1, 3'b011);
        idle(5);

        // whole codebook in order, back-to-back
        for (int k = 0; k < 6; k++) begin
            logic [2:0] order [6] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101};
            step(1'b1, order[k]);
            while (exp_q.size() > 1) step(1'b1, order[k]);
        end
        idle(6);

        // 101, 000, 001: two counted symbols, five bits, one err pulse
        apply_reset();
        step(1'b1, 3'b101);
        while (exp_q.size() > 1) step(1'b1, 3'b101);
        step(1'b1, 3'b000);
        step(1'b1, 3'b001);
        idle(4);

        // random stream, including sym_in changes while not ready
        for (int i = 0; i < 600; i++) begin
            logic v;
            v = ($urandom_range(0, 99) < 65);
            step(v, 3'($urandom_range(0, 7)));
        end
        idle(8);
        check("loop_pending", 32'(sym_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
